alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//  Clocked, parametrised successor to the combinational CPU ALU: same opcode map and N/Z/V semantics, width set by WIDTH.
//  Adds iterative unsigned MULT/DIV, a start/done handshake, registered result and sticky flags.
//  Sits in EX stage; control holds the pipeline while busy is high.
// PARAMETERS
//  WIDTH     32               datapath width in bits; >= 4, power of two
//  SHAMT_W   $clog2(WIDTH)    derived (localparam): shift-amount bits taken from ALU_in2
// PORTS
//  clk       in   1       system clock, all state on rising edge
//  rst_n     in   1       synchronous reset, active-low
//  start     in   1       launch op; sampled only when accepting (state IDLE or DONE)
//  opcode    in   6       ADD 20,ADDI 21,SUB 22,NAND 23,AND 24,ANDI 25,SRL 26,SLL 27,XOR 28,DIV 15,MULT 16,NO_OP 3F (hex)
//  ALU_in1   in   WIDTH   operand A / value to shift / dividend
//  ALU_in2   in   WIDTH   operand B / shamt / divisor
//  ALU_out   out  WIDTH   registered result, held until next completion
//  N         out  1       negative flag (registered, sticky)
//  Z         out  1       zero flag (registered, sticky)
//  V         out  1       overflow flag (registered, sticky)
//  ALU_done  out  1       one-cycle pulse: ALU_out/flags valid this cycle
//  busy      out  1       high while an iterative op (MUL/DIV) is in progress
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state IDLE; ALU_out=0, N=Z=V=0, ALU_done=0, busy=0; any op in flight aborted, no done.
//  States: IDLE, MUL, DIV, DONE. Operands/opcode captured on the accepting edge; inputs may change afterwards.
//  IDLE/DONE + start, single-cycle op -> DONE; result and flags written on that edge; ALU_done=1 next cycle (latency 1).
//  IDLE/DONE + start, MULT/DIV -> MUL/DIV, busy=1, 5-bit-style counter runs WIDTH iterations, then -> DONE (latency WIDTH+1).
//  DONE with no start -> IDLE. start in DONE is accepted (back-to-back ops, 1 op/cycle for single-cycle ops).
//  start while busy: ignored, not queued. opcode/operand changes while busy: no effect.
//  ADD/ADDI/SUB: WIDTH-bit wrap; V = signed overflow (carry into MSB ^ carry out); ADDI identical to ADD.
//  AND/ANDI/NAND/XOR: bitwise; V=0.
//  All of the above: N=ALU_out[WIDTH-1], Z=(ALU_out==0).
//  SLL/SRL: logical, shamt = ALU_in2[SHAMT_W-1:0] (upper bits ignored); N/Z/V unchanged; done asserted.
//  MULT: unsigned shift-add, 2*WIDTH product; ALU_out = low WIDTH bits; V = |high WIDTH bits; N,Z from ALU_out.
//  DIV: unsigned restoring; ALU_out = quotient; V=0; N,Z from quotient.
//  DIV by 0: no iteration; -> DONE directly (latency 1), ALU_out = all ones, V=1, N=1, Z=0.
//  NO_OP and undefined opcodes: latency 1, ALU_done pulses, ALU_out and flags unchanged.
//  ALU_out/flags never change except on a completion edge or reset; never X/Z.
// CONFIGURATION
//  ALU_MULDIV_EN defined: MULT/DIV datapath, counter and MUL/DIV states compiled in as above.
//  ALU_MULDIV_EN undefined: no mul/div logic; opcodes 15/16 behave as undefined (latency 1, outputs/flags unchanged); busy tied 0.
// TESTING (WIDTH=32, ALU_MULDIV_EN defined unless noted)
//  ADD 7FFFFFFF+00000001 -> next cycle ALU_done=1, out 80000000, N=1 Z=0 V=1.
//  SUB 5-5 then back-to-back XOR A5A5A5A5^FFFFFFFF -> out 0 Z=1 N=0 V=0, next cycle out 5A5A5A5A Z=0 N=0 V=0.
//  MULT 1234*5678 -> busy 32 cycles, done at cycle 33, out 006AE9BC V=0; MULT 00010000*00010000 -> out 0 Z=1 V=1.
//  DIV 100/7 -> done at cycle 33, out 0000000E; DIV 5/0 -> done at cycle 1, out FFFFFFFF V=1 N=1.
//  After SUB 5-5 (Z=1): SLL 1 by ALU_in2=0x23 -> out 00000008, done=1, Z still 1; start pulsed mid-DIV ignored.
//  rst_n=0 at DIV iteration 10 -> next cycle out 0, N=Z=V=0, busy=0, no ALU_done; undefined macro: MULT -> done cycle 1, out unchanged.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between EX-stage control and alu_seq.
//   master : drives start, opcode, ALU_in1, ALU_in2; observes results
//   slave  : the ALU; drives ALU_out, N, Z, V, ALU_done, busy
interface alu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [5:0]       opcode;
    logic [WIDTH-1:0] ALU_in1;
    logic [WIDTH-1:0] ALU_in2;
    logic [WIDTH-1:0] ALU_out;
    logic             N;
    logic             Z;
    logic             V;
    logic             ALU_done;
    logic             busy;

    modport master (
        output start, opcode, ALU_in1, ALU_in2,
        input  ALU_out, N, Z, V, ALU_done, busy
    );

    modport slave (
        input  start, opcode, ALU_in1, ALU_in2,
        output ALU_out, N, Z, V, ALU_done, busy
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with start/done handshake, registered result and
// sticky N/Z/V flags. Single-cycle ops complete on the accepting edge;
// unsigned MULT (shift-add) and DIV (restoring) iterate WIDTH cycles.
// Optional feature macro: ALU_MULDIV_EN (mul/div datapath and states).
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : synchronous active-low reset
//   bus   : alu_seq_if.slave (start/opcode/operands in, result/flags/done/busy out)
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  bus
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    localparam logic [5:0] OP_ADD  = 6'h20;
    localparam logic [5:0] OP_ADDI = 6'h21;
    localparam logic [5:0] OP_SUB  = 6'h22;
    localparam logic [5:0] OP_NAND = 6'h23;
    localparam logic [5:0] OP_AND  = 6'h24;
    localparam logic [5:0] OP_ANDI = 6'h25;
    localparam logic [5:0] OP_SRL  = 6'h26;
    localparam logic [5:0] OP_SLL  = 6'h27;
    localparam logic [5:0] OP_XOR  = 6'h28;
`ifdef ALU_MULDIV_EN
    localparam logic [5:0] OP_DIV  = 6'h15;
    localparam logic [5:0] OP_MULT = 6'h16;
`endif

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             n_q, n_d, z_q, z_d, v_q, v_d;
    logic             done_q, done_d;
    logic             set_nz;

    logic [WIDTH-1:0] a, b, add_r, sub_r;

    assign a     = bus.ALU_in1;
    assign b     = bus.ALU_in2;
    assign add_r = a + b;
    assign sub_r = a - b;

`ifdef ALU_MULDIV_EN
    localparam int unsigned CNT_W = SHAMT_W;

    // prod_q holds {hi, lo}: MULT {partial, multiplier}, DIV {remainder, quotient}
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_rem;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;

    // One shift-add / restoring-subtract step on the shared product register
    always_comb begin
        mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, prod_q[WIDTH-1:1]};
        div_rem  = prod_q[2*WIDTH-1:WIDTH-1];
        div_ge   = (div_rem >= {1'b0, opb_q});
        div_next = div_ge ? {WIDTH'(div_rem - {1'b0, opb_q}), prod_q[WIDTH-2:0], 1'b1}
                          : {div_rem[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
    end
`endif

    // Next-state and next-register values
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        n_d     = n_q;
        z_d     = z_q;
        v_d     = v_q;
        done_d  = 1'b0;
        set_nz  = 1'b0;
`ifdef ALU_MULDIV_EN
        busy_d  = 1'b0;
        prod_d  = prod_q;
        opb_d   = opb_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    case (bus.opcode)
                        OP_ADD, OP_ADDI: begin
                            out_d  = add_r;
                            v_d    = (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]);
                            set_nz = 1'b1;
                        end
                        OP_SUB: begin
                            out_d  = sub_r;
                            v_d    = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);
                            set_nz = 1'b1;
                        end
                        OP_NAND: begin
                            out_d  = ~(a & b);
                            v_d    = 1'b0;
                            set_nz = 1'b1;
                        end
                        OP_AND, OP_ANDI: begin
                            out_d  = a & b;
                            v_d    = 1'b0;
                            set_nz = 1'b1;
                        end
                        OP_XOR: begin
                            out_d  = a ^ b;
                            v_d    = 1'b0;
                            set_nz = 1'b1;
                        end
                        OP_SLL: out_d = a << b[SHAMT_W-1:0];
                        OP_SRL: out_d = a >> b[SHAMT_W-1:0];
`ifdef ALU_MULDIV_EN
                        OP_MULT: begin
                            state_d = MUL;
                            done_d  = 1'b0;
                            busy_d  = 1'b1;
                            prod_d  = {{WIDTH{1'b0}}, a};
                            opb_d   = b;
                            cnt_d   = '0;
                        end
                        OP_DIV: begin
                            if (b == '0) begin
                                // divide by zero completes at once with a saturated quotient
                                out_d = '1;
                                n_d   = 1'b1;
                                z_d   = 1'b0;
                                v_d   = 1'b1;
                            end else begin
                                state_d = DIV;
                                done_d  = 1'b0;
                                busy_d  = 1'b1;
                                prod_d  = {{WIDTH{1'b0}}, a};
                                opb_d   = b;
                                cnt_d   = '0;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end
`ifdef ALU_MULDIV_EN
            MUL: begin
                busy_d = 1'b1;
                prod_d = mul_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    out_d   = mul_next[WIDTH-1:0];
                    v_d     = |mul_next[2*WIDTH-1:WIDTH];
                    set_nz  = 1'b1;
                end
            end
            DIV: begin
                busy_d = 1'b1;
                prod_d = div_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    out_d   = div_next[WIDTH-1:0];
                    v_d     = 1'b0;
                    set_nz  = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        if (set_nz) begin
            n_d = out_d[WIDTH-1];
            z_d = (out_d == '0);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Result, flag and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q  <= '0;
            n_q    <= 1'b0;
            z_q    <= 1'b0;
            v_q    <= 1'b0;
            done_q <= 1'b0;
`ifdef ALU_MULDIV_EN
            busy_q <= 1'b0;
            prod_q <= '0;
            opb_q  <= '0;
            cnt_q  <= '0;
`endif
        end else begin
            out_q  <= out_d;
            n_q    <= n_d;
            z_q    <= z_d;
            v_q    <= v_d;
            done_q <= done_d;
`ifdef ALU_MULDIV_EN
            busy_q <= busy_d;
            prod_q <= prod_d;
            opb_q  <= opb_d;
            cnt_q  <= cnt_d;
`endif
        end
    end

    assign bus.ALU_out  = out_q;
    assign bus.N        = n_q;
    assign bus.Z        = z_q;
    assign bus.V        = v_q;
    assign bus.ALU_done = done_q;
`ifdef ALU_MULDIV_EN
    assign bus.busy     = busy_q;
`else
    assign bus.busy     = 1'b0;
`endif
endmodule
